// File: rtl/atm_authenticator.sv
// ATM account core: per-account PIN/balance registers, combinational
// authentication, and one-cycle-latency command execution with lockout.
module atm_authenticator #(
    parameter int NUM_ACCOUNTS = 10,
    parameter int INIT_BALANCE = 500,
    parameter int MAX_TRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] new_pin,
    input  logic [31:0] amount,
    input  logic [2:0]  operation,
    input  logic        op_valid,
    output logic [3:0]  acc_index,
    output logic        acc_found,
    output logic        acc_auth,
    output logic [31:0] balance,
    output logic        success,
    output logic        done
);
    localparam int FW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        OP_BALANCE  = 3'd1,
        OP_WITHDRAW = 3'd2,
        OP_DEPOSIT  = 3'd3,
        OP_CHANGE   = 3'd4
    } op_e;

    logic [31:0]   bal_reg    [NUM_ACCOUNTS];
    logic [15:0]   pin_reg    [NUM_ACCOUNTS];
    logic [FW-1:0] fail_reg   [NUM_ACCOUNTS];
    logic          locked_reg [NUM_ACCOUNTS];

    logic [31:0] balance_reg, balance_next;
    logic        success_reg, success_next;
    logic        done_reg;

    logic [3:0]  idx;
    logic        pin_ok;
    logic        cmd_accept;
    logic [31:0] stored_bal;
    logic [32:0] dep_sum;
    logic        wr_bal, wr_pin, inc_fail, clr_fail;
    logic [31:0] new_bal;

    // Out-of-range accounts map to entry 0 so array reads stay in bounds.
    assign acc_found  = 32'(acc_num) < NUM_ACCOUNTS;
    assign idx        = acc_found ? acc_num : 4'd0;
    assign acc_index  = idx;
    assign pin_ok     = (pin == pin_reg[idx]);
    assign acc_auth   = acc_found && !locked_reg[idx] && pin_ok;
    assign stored_bal = bal_reg[idx];
    assign dep_sum    = {1'b0, stored_bal} + {1'b0, amount};
    assign cmd_accept = op_valid && (operation >= 3'd1) && (operation <= 3'd4);

    always_comb begin
        success_next = 1'b0;
        balance_next = 32'd0;
        wr_bal       = 1'b0;
        wr_pin       = 1'b0;
        inc_fail     = 1'b0;
        clr_fail     = 1'b0;
        new_bal      = stored_bal;
        if (cmd_accept && acc_found && !locked_reg[idx]) begin
            if (!pin_ok) begin
                inc_fail = 1'b1;
            end else begin
                clr_fail = 1'b1;
                case (operation)
                    OP_BALANCE: begin
                        success_next = 1'b1;
                        balance_next = stored_bal;
                    end
                    OP_WITHDRAW: begin
                        balance_next = stored_bal;
                        if (amount <= stored_bal) begin
                            new_bal      = stored_bal - amount;
                            wr_bal       = 1'b1;
                            success_next = 1'b1;
                            balance_next = new_bal;
                        end
                    end
                    OP_DEPOSIT: begin
                        balance_next = stored_bal;
                        if (!dep_sum[32]) begin
                            new_bal      = dep_sum[31:0];
                            wr_bal       = 1'b1;
                            success_next = 1'b1;
                            balance_next = new_bal;
                        end
                    end
                    OP_CHANGE: begin
                        wr_pin       = 1'b1;
                        success_next = 1'b1;
                        balance_next = stored_bal;
                    end
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_acct
            logic hit;
            assign hit = acc_found && (32'(idx) == gi);
            always_ff @(posedge clk) begin
                if (rst) begin
                    bal_reg[gi]    <= 32'(INIT_BALANCE);
                    pin_reg[gi]    <= 16'(gi * 16'h1111);
                    fail_reg[gi]   <= '0;
                    locked_reg[gi] <= 1'b0;
                end else if (hit) begin
                    if (wr_bal)   bal_reg[gi]  <= new_bal;
                    if (wr_pin)   pin_reg[gi]  <= new_pin;
                    if (clr_fail) fail_reg[gi] <= '0;
                    if (inc_fail) begin
                        fail_reg[gi] <= fail_reg[gi] + 1'b1;
                        if (32'(fail_reg[gi]) + 1 >= MAX_TRIES) locked_reg[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Result registers hold their value between commands; done is a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            balance_reg <= 32'd0;
            success_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= op_valid;
            if (op_valid) begin
                balance_reg <= balance_next;
                success_reg <= success_next;
            end
        end
    end

    assign balance = balance_reg;
    assign success = success_reg;
    assign done    = done_reg;
endmodule

// File: tb/tb_atm_authenticator.sv
// Directed bench for atm_authenticator with hand-computed expectations.
module tb_atm_authenticator;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [31:0] amount;
    logic [2:0]  operation;
    logic        op_valid;
    logic [3:0]  acc_index;
    logic        acc_found;
    logic        acc_auth;
    logic [31:0] balance;
    logic        success;
    logic        done;

    int checks   = 0;
    int failures = 0;

    atm_authenticator dut (
        .clk(clk), .rst(rst), .acc_num(acc_num), .pin(pin), .new_pin(new_pin),
        .amount(amount), .operation(operation), .op_valid(op_valid),
        .acc_index(acc_index), .acc_found(acc_found), .acc_auth(acc_auth),
        .balance(balance), .success(success), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cmd(input logic [3:0] a, input logic [15:0] p, input logic [2:0] op,
                       input logic [31:0] amt, input logic [15:0] np);
        acc_num = a; pin = p; operation = op; amount = amt; new_pin = np; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic result(input string tag, input logic exp_s, input logic [31:0] exp_b);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".success"}, 32'(success), 32'(exp_s));
        check({tag, ".balance"}, balance, exp_b);
    endtask

    task automatic auth(input string tag, input logic [3:0] a, input logic [15:0] p,
                        input logic exp_f, input logic exp_a, input logic [3:0] exp_i);
        acc_num = a; pin = p;
        #1;
        check({tag, ".found"}, 32'(acc_found), 32'(exp_f));
        check({tag, ".auth"}, 32'(acc_auth), 32'(exp_a));
        check({tag, ".index"}, 32'(acc_index), 32'(exp_i));
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; acc_num = 0; pin = 0; new_pin = 0; amount = 0; operation = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.balance", balance, 32'd0);
        check("rst.success", 32'(success), 32'd0);
        check("rst.done", 32'(done), 32'd0);

        auth("a3", 4'd3, 16'h3333, 1, 1, 4'd3);
        cmd(4'd3, 16'h3333, 3'd1, 0, 0);
        result("bal3", 1, 32'd500);
        @(posedge clk); #1;
        check("idle.done", 32'(done), 32'd0);
        check("idle.balance", balance, 32'd500);

        cmd(4'd2, 16'h2222, 3'd2, 32'd200, 0); result("wd200", 1, 32'd300);
        cmd(4'd2, 16'h2222, 3'd2, 32'd301, 0); result("wd301", 0, 32'd300);
        cmd(4'd2, 16'h2222, 3'd3, 32'd50, 0);  result("dep50", 1, 32'd350);
        cmd(4'd2, 16'h2222, 3'd2, 32'd0, 0);   result("wd0", 1, 32'd350);
        cmd(4'd2, 16'h2222, 3'd2, 32'd350, 0); result("wdall", 1, 32'd0);
        cmd(4'd2, 16'h2222, 3'd1, 0, 0);       result("bal2", 1, 32'd0);

        cmd(4'd5, 16'h5555, 3'd3, 32'hFFFF_FE0C, 0); result("depovf", 0, 32'd500);
        cmd(4'd5, 16'h5555, 3'd3, 32'hFFFF_FE0B, 0); result("depmax", 1, 32'hFFFF_FFFF);

        auth("a12", 4'd12, 16'h0000, 0, 0, 4'd0);
        cmd(4'd12, 16'h0000, 3'd1, 0, 0); result("bad_acc", 0, 32'd0);

        cmd(4'd3, 16'h3333, 3'd0, 0, 0); result("nop0", 0, 32'd0);
        cmd(4'd3, 16'h3333, 3'd6, 0, 0); result("nop6", 0, 32'd0);
        cmd(4'd3, 16'h3333, 3'd1, 0, 0); result("bal3b", 1, 32'd500);

        cmd(4'd1, 16'h1111, 3'd4, 0, 16'hBEEF); result("chpin", 1, 32'd500);
        auth("a1old", 4'd1, 16'h1111, 1, 0, 4'd1);
        auth("a1new", 4'd1, 16'hBEEF, 1, 1, 4'd1);

        cmd(4'd7, 16'h0000, 3'd1, 0, 0); result("bad7a", 0, 32'd0);
        cmd(4'd7, 16'h0000, 3'd1, 0, 0); result("bad7b", 0, 32'd0);
        auth("a7two", 4'd7, 16'h7777, 1, 1, 4'd7);
        cmd(4'd7, 16'h0000, 3'd1, 0, 0); result("bad7c", 0, 32'd0);
        auth("a7lock", 4'd7, 16'h7777, 1, 0, 4'd7);
        cmd(4'd7, 16'h7777, 3'd1, 0, 0); result("lock7", 0, 32'd0);

        // Command presented during reset must be discarded.
        rst = 1'b1;
        cmd(4'd3, 16'h3333, 3'd2, 32'd100, 0);
        rst = 1'b0;
        check("rstcmd.done", 32'(done), 32'd0);
        auth("a7rst", 4'd7, 16'h7777, 1, 1, 4'd7);
        auth("a1rst", 4'd1, 16'h1111, 1, 1, 4'd1);
        cmd(4'd3, 16'h3333, 3'd1, 0, 0); result("bal3rst", 1, 32'd500);
        cmd(4'd2, 16'h2222, 3'd1, 0, 0); result("bal2rst", 1, 32'd500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
